block_scheduler: RTL and testbench
==================================

Name: block_scheduler

Overview:
- Parametrised successor to the single-kernel block dispatcher.
- Splits a kernel launch of thread_count threads into blocks of a runtime-selected size and hands them to NUM_CORES compute cores.
- Retires any number of core completions per cycle, supports a per-launch block size and an abort, and signals kernel completion to the GPU top level.
- Sits between the device control register / host start and the core array.

Parameters:
- NUM_CORES, 2, number of cores managed (1..32)
- MAX_THREADS_PER_BLOCK, 4, hardware thread slots per core; upper bound on block size
- THREAD_COUNT_W, 8, width of thread_count and of internal remaining-thread counter
- BLOCK_ID_W, 8, width of block ids and block counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  launch request; level, held high by host until done seen
- abort  in  1  one-cycle pulse; cancel current launch
- thread_count  in  THREAD_COUNT_W  total threads; sampled at launch
- block_threads  in  $clog2(MAX_THREADS_PER_BLOCK)+1  requested block size; sampled at launch
- core_done  in  NUM_CORES  per-core block-complete
- core_start  out  NUM_CORES  core owns a block; held until its done is retired
- core_reset  out  NUM_CORES  one-cycle pulse clearing a core
- core_block_id  out  NUM_CORES x BLOCK_ID_W  block id per core
- core_thread_count  out  NUM_CORES x ($clog2(MAX_THREADS_PER_BLOCK)+1)  active threads per core
- blocks_done  out  BLOCK_ID_W  blocks retired this launch
- busy  out  1  launch in progress
- done  out  1  kernel complete; held

Behaviour:
- Reset (sync, priority over all): state=IDLE; core_start=0, core_reset=all 1s for that cycle, core_block_id=0, core_thread_count=MAX_THREADS_PER_BLOCK, blocks_done=0, busy=0, done=0. Reset mid-launch discards all progress.
- States: IDLE, CLEAR, DISPATCH, DONE.
- IDLE:
  - start=1 -> latch thread_count into remaining and the effective block size into bsz; next_id=0, blocks_done=0; go to CLEAR.
  - Effective block size: block_threads if 1..MAX, else MAX (0 or >MAX clamps to MAX).
- CLEAR: core_reset=all 1s for exactly one cycle; busy=1; then DISPATCH.
- DISPATCH, each cycle:
  - Retire: for every core i with core_start[i]=1 and core_done[i]=1: core_start[i]<=0, core_reset[i]<=1 for one cycle. blocks_done += popcount of retired cores (multiple retirements per cycle allowed). core_done is ignored when core_start=0.
  - Issue: if remaining>0, assign one block per cycle to the lowest-index core with core_start=0 that is not being retired this cycle.
    - core_block_id=next_id; core_thread_count=min(remaining,bsz).
    - remaining-=that value; next_id+=1. No division is used.
    - core_start rises the cycle after the assignment.
  - Exit: remaining=0 and no core_start set -> DONE.
  - Block ids wrap modulo 2^BLOCK_ID_W; the host keeps block count <=2^BLOCK_ID_W.
- DONE: done=1, busy=0; hold until start=0, then IDLE (done<=0). A still-high start does not relaunch.
- thread_count=0: CLEAR -> DISPATCH -> DONE with no core_start pulse; blocks_done=0.
- abort in CLEAR or DISPATCH: core_start<=0, core_reset<=all 1s for one cycle, remaining<=0, state=DONE with done=1. blocks_done freezes at its value in the abort cycle, including same-cycle retirements. abort is ignored in IDLE and DONE.
- The start level is only examined in IDLE and DONE.

Optional Feature:
- Macro BLOCK_SCHED_PERF_EN.
- Defined:
  - Adds output kernel_cycles [31:0].
  - Cleared on the IDLE->CLEAR transition; increments every cycle in CLEAR and DISPATCH; holds in DONE; saturates at all 1s.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- NUM_CORES=2, MAX=4, thread_count=8, block_threads=4, each core's done 3 cycles after its start:
  - core0 receives id0/cnt4 and core1 receives id1/cnt4, one cycle apart.
  - blocks_done=2, then done=1.
- thread_count=10, block_threads=4:
  - blocks 0..2 have counts 4, 4, 2; block 2 reuses the first retired core.
  - blocks_done=3.
- block_threads=0 and block_threads=7 with thread_count=8: both behave as size 4 (2 blocks).
- Both cores assert core_done in the same cycle:
  - blocks_done increments by 2 in one cycle.
  - Both core_reset pulses coincide.
- thread_count=0: done=1 within 3 cycles of start; core_start never rises.
- abort during block 1 of a 4-block launch, then reset mid-launch:
  - abort: all core_start=0 next cycle and done=1.
  - reset: all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/block_scheduler.sv
// Kernel block scheduler: splits a launch into blocks and hands them to NUM_CORES cores.
// Optional BLOCK_SCHED_PERF_EN adds the kernel_cycles launch-duration counter.
module block_scheduler #(
  parameter int NUM_CORES             = 2,
  parameter int MAX_THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_W        = 8,
  parameter int BLOCK_ID_W            = 8
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      start,
  input  logic                                                      abort,
  input  logic [THREAD_COUNT_W-1:0]                                 thread_count,
  input  logic [$clog2(MAX_THREADS_PER_BLOCK):0]                    block_threads,
  input  logic [NUM_CORES-1:0]                                      core_done,
  output logic [NUM_CORES-1:0]                                      core_start,
  output logic [NUM_CORES-1:0]                                      core_reset,
  output logic [NUM_CORES*BLOCK_ID_W-1:0]                           core_block_id,
  output logic [NUM_CORES*($clog2(MAX_THREADS_PER_BLOCK)+1)-1:0]    core_thread_count,
  output logic [BLOCK_ID_W-1:0]                                     blocks_done,
  output logic                                                      busy,
  output logic                                                      done
`ifdef BLOCK_SCHED_PERF_EN
  ,
  output logic [31:0]                                               kernel_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_THREADS_PER_BLOCK) + 1;
  localparam int TC_W  = THREAD_COUNT_W;
  localparam int EXT_W = TC_W + CNT_W;
  localparam logic [CNT_W-1:0] MAX_BSZ = CNT_W'(MAX_THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DISPATCH,
    S_DONE
  } state_t;

  state_t                                r_state, w_state_nx;
  logic [NUM_CORES-1:0]                  r_core_start, w_core_start_nx;
  logic [NUM_CORES-1:0]                  r_core_reset, w_core_reset_nx;
  logic [NUM_CORES-1:0][BLOCK_ID_W-1:0]  r_bid, w_bid_nx;
  logic [NUM_CORES-1:0][CNT_W-1:0]       r_tcnt, w_tcnt_nx;
  logic [BLOCK_ID_W-1:0]                 r_blocks_done, w_blocks_done_nx;
  logic                                  r_busy, w_busy_nx;
  logic                                  r_done, w_done_nx;
  logic [TC_W-1:0]                       r_rem, w_rem_nx;
  logic [CNT_W-1:0]                      r_bsz, w_bsz_nx;
  logic [BLOCK_ID_W-1:0]                 r_next_id, w_next_id_nx;
  logic [NUM_CORES-1:0]                  w_retire;
  logic [CNT_W-1:0]                      w_take;
  logic                                  w_found;

  function automatic logic [CNT_W-1:0] f_clamp(input logic [CNT_W-1:0] bt);
    if (bt == '0 || bt > MAX_BSZ) return MAX_BSZ;
    return bt;
  endfunction

  function automatic logic [CNT_W-1:0] f_take(input logic [TC_W-1:0] rem,
                                              input logic [CNT_W-1:0] bsz);
    logic [EXT_W-1:0] rem_ext;
    logic [EXT_W-1:0] bsz_ext;
    rem_ext = {{CNT_W{1'b0}}, rem};
    bsz_ext = {{TC_W{1'b0}}, bsz};
    if (rem_ext < bsz_ext) return rem_ext[CNT_W-1:0];
    return bsz;
  endfunction

  function automatic logic [TC_W-1:0] f_sub(input logic [TC_W-1:0] rem,
                                            input logic [CNT_W-1:0] take);
    logic [EXT_W-1:0] diff;
    diff = {{CNT_W{1'b0}}, rem} - {{TC_W{1'b0}}, take};
    return diff[TC_W-1:0];
  endfunction

  function automatic logic [BLOCK_ID_W-1:0] f_popcount(input logic [NUM_CORES-1:0] v);
    logic [BLOCK_ID_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CORES; i++) c = c + BLOCK_ID_W'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_core_start  <= '0;
      r_core_reset  <= '1;
      r_bid         <= '0;
      r_tcnt        <= {NUM_CORES{MAX_BSZ}};
      r_blocks_done <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rem         <= '0;
      r_bsz         <= MAX_BSZ;
      r_next_id     <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_core_start  <= w_core_start_nx;
      r_core_reset  <= w_core_reset_nx;
      r_bid         <= w_bid_nx;
      r_tcnt        <= w_tcnt_nx;
      r_blocks_done <= w_blocks_done_nx;
      r_busy        <= w_busy_nx;
      r_done        <= w_done_nx;
      r_rem         <= w_rem_nx;
      r_bsz         <= w_bsz_nx;
      r_next_id     <= w_next_id_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_core_start_nx  = r_core_start;
    w_core_reset_nx  = '0;
    w_bid_nx         = r_bid;
    w_tcnt_nx        = r_tcnt;
    w_blocks_done_nx = r_blocks_done;
    w_busy_nx        = r_busy;
    w_done_nx        = r_done;
    w_rem_nx         = r_rem;
    w_bsz_nx         = r_bsz;
    w_next_id_nx     = r_next_id;
    w_retire         = '0;
    w_found          = 1'b0;
    w_take           = f_take(r_rem, r_bsz);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rem_nx         = thread_count;
          w_bsz_nx         = f_clamp(block_threads);
          w_next_id_nx     = '0;
          w_blocks_done_nx = '0;
          w_core_reset_nx  = '1;
          w_busy_nx        = 1'b1;
          w_state_nx       = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (abort) begin
          w_core_start_nx = '0;
          w_core_reset_nx = '1;
          w_rem_nx        = '0;
          w_busy_nx       = 1'b0;
          w_done_nx       = 1'b1;
          w_state_nx      = S_DONE;
        end else begin
          w_state_nx = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        // Retirements count even in an abort cycle, so blocks_done freezes after them.
        w_retire         = r_core_start & core_done;
        w_blocks_done_nx = r_blocks_done + f_popcount(w_retire);
        if (abort) begin
          w_core_start_nx = '0;
          w_core_reset_nx = '1;
          w_rem_nx        = '0;
          w_busy_nx       = 1'b0;
          w_done_nx       = 1'b1;
          w_state_nx      = S_DONE;
        end else begin
          w_core_start_nx = r_core_start & ~w_retire;
          w_core_reset_nx = w_retire;
          if (r_rem != '0) begin
            // A retiring core still has core_start set, so it is never picked here.
            for (int i = 0; i < NUM_CORES; i++) begin
              if (!w_found && !r_core_start[i]) begin
                w_found            = 1'b1;
                w_core_start_nx[i] = 1'b1;
                w_bid_nx[i]        = r_next_id;
                w_tcnt_nx[i]       = w_take;
              end
            end
            if (w_found) begin
              w_rem_nx     = f_sub(r_rem, w_take);
              w_next_id_nx = r_next_id + BLOCK_ID_W'(1);
            end
          end else if (r_core_start == '0) begin
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_state_nx = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!start) begin
          w_done_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  assign core_start        = r_core_start;
  assign core_reset        = r_core_reset;
  assign core_block_id     = r_bid;
  assign core_thread_count = r_tcnt;
  assign blocks_done       = r_blocks_done;
  assign busy              = r_busy;
  assign done              = r_done;

`ifdef BLOCK_SCHED_PERF_EN
  logic [31:0] r_kernel_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kernel_cycles <= '0;
    end else if (r_state == S_IDLE && w_state_nx == S_CLEAR) begin
      r_kernel_cycles <= '0;
    end else if ((r_state == S_CLEAR || r_state == S_DISPATCH) && r_kernel_cycles != '1) begin
      r_kernel_cycles <= r_kernel_cycles + 32'd1;
    end
  end

  assign kernel_cycles = r_kernel_cycles;
`else
  // Without the performance option there is no launch-duration counter.
`endif

endmodule

// File: tb/tb_block_scheduler.sv
// Randomised scoreboard bench for block_scheduler with directed launch, abort and reset cases.
module tb_block_scheduler;
  localparam int NC   = 2;
  localparam int MAXT = 4;
  localparam int TCW  = 8;
  localparam int BIDW = 8;
  localparam int CW   = 3;

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic [TCW-1:0]     thread_count;
  logic [CW-1:0]      block_threads;
  logic [NC-1:0]      core_done = '0;
  logic [NC-1:0]      core_start, core_reset;
  logic [NC*BIDW-1:0] core_block_id;
  logic [NC*CW-1:0]   core_thread_count;
  logic [BIDW-1:0]    blocks_done;
  logic               busy, done;
`ifdef BLOCK_SCHED_PERF_EN
  logic [31:0]        kernel_cycles;
`endif

  always #5 clk = ~clk;

  block_scheduler #(
    .NUM_CORES(NC), .MAX_THREADS_PER_BLOCK(MAXT), .THREAD_COUNT_W(TCW), .BLOCK_ID_W(BIDW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .thread_count(thread_count), .block_threads(block_threads), .core_done(core_done),
    .core_start(core_start), .core_reset(core_reset), .core_block_id(core_block_id),
    .core_thread_count(core_thread_count), .blocks_done(blocks_done),
    .busy(busy), .done(done)
`ifdef BLOCK_SCHED_PERF_EN
    , .kernel_cycles(kernel_cycles)
`endif
  );

  typedef struct {
    int id;
    int cnt;
  } blk_t;

  blk_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            manual   = 1'b0;
  logic [NC-1:0] manual_done = '0;
  bit            started[NC];
  int            lat[NC];
  logic [NC-1:0] prev_start = '0;
  logic          prev_busy  = 1'b0;
  int            model_bd   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference split of a launch: consecutive ids, each block min(remaining, size).
  function automatic int push_blocks(input int t, input int bt);
    int   b, rem, id;
    blk_t e;
    b   = (bt == 0 || bt > MAXT) ? MAXT : bt;
    rem = t;
    id  = 0;
    while (rem > 0) begin
      e.cnt = (rem < b) ? rem : b;
      e.id  = id % (1 << BIDW);
      exp_q.push_back(e);
      rem -= e.cnt;
      id++;
    end
    return id;
  endfunction

  // Core array stand-in: random work latency, plus stray done pulses on idle cores.
  always @(negedge clk) begin
    logic [NC-1:0] cd;
    #2;
    cd = '0;
    for (int i = 0; i < NC; i++) begin
      if (core_start[i] === 1'b1) begin
        if (!started[i]) begin
          started[i] = 1'b1;
          lat[i]     = $urandom_range(0, 3);
        end
        if (lat[i] == 0) cd[i] = 1'b1;
        else lat[i]--;
      end else begin
        started[i] = 1'b0;
        cd[i]      = ($urandom_range(0, 3) == 0);
      end
    end
    core_done = manual ? manual_done : cd;
  end

  // Monitor: retirement effects, running blocks_done, and issued blocks against the queue.
  always @(negedge clk) begin
    logic [NC-1:0] retired, rises;
    int            exp_core, got_core;
    blk_t          e;
    if (reset !== 1'b1) begin
      retired = prev_start & core_done & {NC{prev_busy}};
      for (int i = 0; i < NC; i++)
        if (retired[i]) chk("retire_start_reset", {62'd0, core_start[i], core_reset[i]}, 64'd1);
      model_bd += $countones(retired);
      if (busy && !prev_busy) model_bd = 0;
      if (busy || prev_busy) chk("blocks_done_running", blocks_done, model_bd % (1 << BIDW));
      rises = core_start & ~prev_start;
      if (rises != '0) begin
        chk("one_issue_per_cycle", $countones(rises), 1);
        exp_core = -1;
        got_core = -1;
        for (int i = NC - 1; i >= 0; i--) begin
          if (!prev_start[i]) exp_core = i;
          if (rises[i]) got_core = i;
        end
        chk("issue_lowest_free_core", got_core, exp_core);
        chk("issue_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("block_id", core_block_id[got_core*BIDW +: BIDW], e.id);
          chk("block_thread_count", core_thread_count[got_core*CW +: CW], e.cnt);
        end
      end
    end else begin
      model_bd = 0;
    end
    prev_start = core_start;
    prev_busy  = busy;
  end

  task automatic chk_reset_vals();
    chk("rst_core_start", core_start, 0);
    chk("rst_core_reset", core_reset, {NC{1'b1}});
    chk("rst_block_id", core_block_id, 0);
    chk("rst_thread_count", core_thread_count, {NC{3'd4}});
    chk("rst_blocks_done", blocks_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic drive_start(input int t, input int bt);
    @(negedge clk);
    #1;
    thread_count  = t[TCW-1:0];
    block_threads = bt[CW-1:0];
    start         = 1'b1;
  endtask

  task automatic finish_launch(input int n, input int t);
    int cyc, busy_cyc;
    bit seen;
    cyc = 0; busy_cyc = 0; seen = 1'b0;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("final_blocks_done", blocks_done, n % (1 << BIDW));
    chk("queue_drained", exp_q.size(), 0);
    chk("cores_idle_at_done", core_start, 0);
    chk("busy_low_at_done", busy, 0);
    if (t == 0) chk("zero_launch_latency_ok", cyc <= 3, 1);
`ifdef BLOCK_SCHED_PERF_EN
    chk("kernel_cycles", kernel_cycles, busy_cyc);
`endif
    repeat (2) @(negedge clk);
    chk("done_held", done, 1);
    chk("no_relaunch", busy, 0);
    #1 start = 1'b0;
    @(negedge clk);
    chk("done_cleared", done, 0);
    exp_q.delete();
  endtask

  task automatic launch(input int t, input int bt);
    int n;
    n = push_blocks(t, bt);
    drive_start(t, bt);
    finish_launch(n, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    reset = 1'b1; start = 1'b0; abort = 1'b0; thread_count = '0; block_threads = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    #1 reset = 1'b0;

    launch(8, 4);
    launch(10, 4);
    launch(8, 0);
    launch(8, 7);
    launch(0, 4);

    // Both cores complete in the same cycle.
    manual = 1'b1; manual_done = '0;
    n = push_blocks(8, 4);
    drive_start(8, 4);
    cyc = 0;
    while (core_start !== 2'b11 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("both_cores_owned", core_start, 2'b11);
    #1 manual_done = 2'b11;
    @(negedge clk);
    chk("dual_retire_count", blocks_done, 2);
    chk("dual_reset_pulse", core_reset, 2'b11);
    #1 manual_done = '0; manual = 1'b0;
    finish_launch(n, 8);

    for (int k = 0; k < 30; k++) launch($urandom_range(0, 40), $urandom_range(0, 7));

    // Abort while block 1 is running on a 4-block launch.
    manual = 1'b1; manual_done = '0;
    n = push_blocks(16, 4);
    drive_start(16, 4);
    cyc = 0;
    while (core_start[1] !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("abort_block1_running", core_start[1], 1);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_cores_stopped", core_start, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_reset_pulse", core_reset, {NC{1'b1}});
    chk("abort_blocks_frozen", blocks_done, 0);
    #1 abort = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_done_held", done, 1);
    chk("abort_no_issue", core_start, 0);
    #1 start = 1'b0;
    @(negedge clk);
    chk("abort_done_cleared", done, 0);

    // Reset in the middle of a launch.
    n = push_blocks(16, 4);
    drive_start(16, 4);
    cyc = 0;
    while (core_start === '0 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("reset_launch_active", core_start != '0, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    #1 reset = 1'b0; start = 1'b0; manual = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_idle_done", done, 0);
    launch(9, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
